// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and defaults for the hazard controller and its MDU timer.
package hazard_ctrl_pkg;
   typedef enum logic [1:0] {MDU_IDLE, MDU_BUSY, MDU_DONE} mdu_state_e;
   localparam int DEF_MULT_CYCLES = 4;
   localparam int DEF_DIV_CYCLES  = 33;
   localparam int REG_W           = 5;
endpackage

// File: rtl/hazard_ctrl_mdu_busy_timer.sv
// mdu_busy_timer: tracks an in-flight multiply/divide and pulses done when its latency elapses.
module mdu_busy_timer
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   input  logic is_div_i,
   input  logic block_i,
   output logic busy_o,
   output logic done_o
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);
   mdu_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          go;
   assign go = start_i & ~block_i;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         MDU_BUSY: begin
            state_d = (cnt_q == '0) ? MDU_DONE : MDU_BUSY;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
         end
         default: begin
            state_d = go ? MDU_BUSY : MDU_IDLE;
            cnt_d   = go ? (is_div_i ? DIV_LD : MULT_LD) : cnt_q;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MDU_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   assign busy_o = (state_q == MDU_BUSY);
   assign done_o = (state_q == MDU_DONE);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / MDU stall detection, flush priority and stall accounting for the pipeline.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_mdu_use,
   input  logic             ex_is_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             mdu_start,
   input  logic             mdu_is_div,
   input  logic             branch_taken,
   input  logic             exc_flush,
   output logic             pc_ena,
   output logic             if_id_ena,
   output logic             if_id_flush,
   output logic             id_exe_flush,
   output logic             exe_mem_flush,
   output logic             mdu_busy,
   output logic             mdu_done,
   output logic [31:0]      stall_count
);
   logic        load_use, mdu_haz, stall;
   logic [31:0] stall_count_q, stall_count_d;
   mdu_busy_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .start_i  (mdu_start),
      .is_div_i (mdu_is_div),
      .block_i  (exc_flush),
      .busy_o   (mdu_busy),
      .done_o   (mdu_done)
   );
   assign load_use = ex_is_load & (ex_rd != '0) &
                     ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
   assign mdu_haz  = mdu_busy & id_mdu_use;
   // An exception flush always wins: it restarts fetch, so holding the front end is pointless.
   assign stall         = (load_use | mdu_haz) & ~exc_flush;
   assign pc_ena        = ~stall;
   assign if_id_ena     = ~stall;
   assign if_id_flush   = exc_flush | (branch_taken & ~stall);
   assign id_exe_flush  = exc_flush | stall;
   assign exe_mem_flush = exc_flush;
   assign stall_count_d = (stall && stall_count_q != 32'hFFFF_FFFF) ? stall_count_q + 32'd1 : stall_count_q;
   always_ff @(posedge clk) begin
      if (reset) stall_count_q <= '0;
      else       stall_count_q <= stall_count_d;
   end
   assign stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table vectors, directed corner sequences and random stimulus against a cycle-indexed model.
module tb_hazard_ctrl;
   logic clk = 0, reset;
   logic [4:0] id_rs, id_rt, ex_rd;
   logic id_uses_rs, id_uses_rt, id_mdu_use, ex_is_load, mdu_start, mdu_is_div, branch_taken, exc_flush;
   logic pc_ena, if_id_ena, if_id_flush, id_exe_flush, exe_mem_flush, mdu_busy, mdu_done;
   logic [31:0] stall_count;
   int checks = 0, errors = 0;
   int cyc = 0, bs = 1, be = 0, dn = -1;
   longint m_cnt = 0;
   always #5 clk = ~clk;
   hazard_ctrl dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
      .id_uses_rt(id_uses_rt), .id_mdu_use(id_mdu_use), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .mdu_start(mdu_start), .mdu_is_div(mdu_is_div), .branch_taken(branch_taken), .exc_flush(exc_flush),
      .pc_ena(pc_ena), .if_id_ena(if_id_ena), .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
      .exe_mem_flush(exe_mem_flush), .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_count(stall_count)
   );
   typedef struct {
      logic ld; logic [4:0] rd, rs, rt; logic urs, urt, br, exc;
      logic e_pc, e_ifl, e_idl, e_eml;
   } vec_t;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask
   task automatic clear();
      reset = 0; id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rs = 0; id_uses_rt = 0; id_mdu_use = 0;
      ex_is_load = 0; mdu_start = 0; mdu_is_div = 0; branch_taken = 0; exc_flush = 0;
   endtask
   function automatic bit m_busy();
      return cyc >= bs && cyc <= be;
   endfunction
   task automatic check_cycle();
      bit lu, st;
      @(negedge clk);
      lu = ex_is_load && ex_rd != 0 && ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
      st = (lu || (m_busy() && id_mdu_use)) && !exc_flush;
      chk("pc_ena", pc_ena, !st);
      chk("if_id_ena", if_id_ena, !st);
      chk("if_id_flush", if_id_flush, exc_flush || (branch_taken && !st));
      chk("id_exe_flush", id_exe_flush, exc_flush || st);
      chk("exe_mem_flush", exe_mem_flush, exc_flush);
      chk("mdu_busy", mdu_busy, m_busy());
      chk("mdu_done", mdu_done, cyc == dn);
      chk("stall_count", stall_count, m_cnt[31:0]);
   endtask
   task automatic advance();
      bit lu, st;
      lu = ex_is_load && ex_rd != 0 && ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
      st = (lu || (m_busy() && id_mdu_use)) && !exc_flush;
      @(posedge clk);
      if (reset) begin
         m_cnt = 0; bs = cyc + 2; be = cyc; dn = -1;
      end else begin
         if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
         if (mdu_start && !exc_flush && !m_busy()) begin
            bs = cyc + 1;
            be = cyc + (mdu_is_div ? 33 : 4);
            dn = be + 1;
         end
      end
      cyc++;
      #1;
   endtask
   task automatic step();
      check_cycle();
      advance();
   endtask
   task automatic do_reset();
      clear(); reset = 1; step(); step(); reset = 0;
   endtask
   initial begin
      vec_t tbl[8];
      int nb, ns, dc, nd;
      logic [31:0] sc;
      tbl[0] = '{1, 8, 8, 0, 1, 0, 0, 0, 0, 0, 1, 0};
      tbl[1] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
      tbl[2] = '{1, 9, 1, 9, 0, 1, 0, 0, 0, 0, 1, 0};
      tbl[3] = '{1, 9, 9, 9, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[4] = '{0, 8, 8, 8, 1, 1, 1, 0, 1, 1, 0, 0};
      tbl[5] = '{1, 8, 8, 0, 1, 0, 1, 0, 0, 0, 1, 0};
      tbl[6] = '{1, 8, 8, 0, 1, 0, 1, 1, 1, 1, 1, 1};
      tbl[7] = '{1, 31, 30, 31, 1, 0, 1, 0, 1, 1, 0, 0};
      clear();
      reset = 1;
      @(posedge clk); #1;
      step();
      reset = 0;
      chk("reset_busy", mdu_busy, 0);
      chk("reset_done", mdu_done, 0);
      chk("reset_stall_count", stall_count, 0);
      foreach (tbl[i]) begin
         clear();
         ex_is_load = tbl[i].ld; ex_rd = tbl[i].rd; id_rs = tbl[i].rs; id_rt = tbl[i].rt;
         id_uses_rs = tbl[i].urs; id_uses_rt = tbl[i].urt; branch_taken = tbl[i].br; exc_flush = tbl[i].exc;
         sc = stall_count;
         check_cycle();
         chk($sformatf("tbl%0d_pc_ena", i), pc_ena, tbl[i].e_pc);
         chk($sformatf("tbl%0d_if_id_ena", i), if_id_ena, tbl[i].e_pc);
         chk($sformatf("tbl%0d_if_id_flush", i), if_id_flush, tbl[i].e_ifl);
         chk($sformatf("tbl%0d_id_exe_flush", i), id_exe_flush, tbl[i].e_idl);
         chk($sformatf("tbl%0d_exe_mem_flush", i), exe_mem_flush, tbl[i].e_eml);
         advance();
         chk($sformatf("tbl%0d_stall_inc", i), stall_count, sc + (tbl[i].e_pc ? 0 : 1));
      end
      do_reset();
      ex_is_load = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1; branch_taken = 1;
      check_cycle();
      chk("br_stalled_flush", if_id_flush, 0);
      advance();
      chk("load_use_count", stall_count, 1);
      clear(); branch_taken = 1;
      check_cycle();
      chk("br_represent_flush", if_id_flush, 1);
      advance();
      do_reset();
      id_mdu_use = 1; mdu_is_div = 1;
      nb = 0; ns = 0; dc = -1;
      for (int i = 0; i < 36; i++) begin
         mdu_start = (i == 0);
         check_cycle();
         if (mdu_busy) nb++;
         if (!pc_ena) ns++;
         if (mdu_done) dc = i;
         advance();
      end
      chk("div_busy_cycles", nb, 33);
      chk("div_stall_cycles", ns, 33);
      chk("div_done_cycle", dc, 34);
      chk("div_stall_count", stall_count, 33);
      do_reset();
      id_mdu_use = 1; mdu_start = 1;
      step();
      mdu_start = 0;
      step();
      reset = 1;
      step();
      reset = 0; id_mdu_use = 0;
      chk("rst_mid_mul_busy", mdu_busy, 0);
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         check_cycle();
         if (mdu_done) nd++;
         advance();
      end
      chk("rst_mid_mul_done", nd, 0);
      chk("rst_mid_mul_count", stall_count, 0);
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(63) == 0);
         ex_is_load = $urandom_range(1); ex_rd = 5'($urandom_range(3));
         id_rs = 5'($urandom_range(3)); id_rt = 5'($urandom_range(3));
         id_uses_rs = $urandom_range(1); id_uses_rt = $urandom_range(1);
         id_mdu_use = $urandom_range(1); mdu_start = ($urandom_range(7) == 0);
         mdu_is_div = ($urandom_range(3) == 0); branch_taken = $urandom_range(1);
         exc_flush = ($urandom_range(7) == 0);
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 4, latency in cycles of a multiply in the mult/div unit (MDU).
REQ-002 Parameter DIV_CYCLES, default 33, latency in cycles of a divide in the MDU.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the ID-stage instruction.
REQ-006 id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-007 id_mdu_use  in  1  ID instruction reads HI/LO or starts an MDU op.
REQ-008 ex_is_load, ex_rd  in  1, 5  EX instruction is a load; its destination register.
REQ-009 mdu_start, mdu_is_div  in  1 each  EX-stage MDU op issues this cycle; the op is a divide.
REQ-010 branch_taken  in  1  ID-stage branch/jump resolved taken.
REQ-011 exc_flush  in  1  exception or eret committed in MEM.
REQ-012 pc_ena, if_id_ena  out  1 each  PC and IF/ID register update enables.
REQ-013 if_id_flush, id_exe_flush, exe_mem_flush  out  1 each  insert a bubble into the named register.
REQ-014 mdu_busy, mdu_done  out  1 each  MDU op in flight; one-cycle completion pulse.
REQ-015 stall_count  out  32  count of stalled cycles since reset.

Function
REQ-016 Load-use hazard = ex_is_load & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)); combinational, same cycle.
REQ-017 MDU hazard = mdu_busy & id_mdu_use; combinational, same cycle.
REQ-018 Stall = (load-use | MDU hazard) & !exc_flush; during a stall: pc_ena=0, if_id_ena=0, id_exe_flush=1.
REQ-019 When there is no stall: pc_ena=1 and if_id_ena=1.
REQ-020 if_id_flush=1 when branch_taken & !stall; a stalled branch is ignored and is reevaluated when it re-presents.
REQ-021 exc_flush=1 forces if_id_flush=id_exe_flush=exe_mem_flush=1 and pc_ena=if_id_ena=1, overriding stall and branch.
REQ-022 MDU FSM states: IDLE, BUSY, DONE.
REQ-023 IDLE: on mdu_start & !exc_flush, load counter with (mdu_is_div ? DIV_CYCLES : MULT_CYCLES)-1 and go to BUSY.
REQ-024 BUSY: decrement the counter each cycle; when the counter is 0, go to DONE.
REQ-025 DONE: lasts one cycle, then returns to IDLE; mdu_start in DONE behaves as in IDLE, going to BUSY next cycle.
REQ-026 mdu_busy=1 in BUSY; mdu_done=1 only in DONE.
REQ-027 mdu_start while in BUSY is ignored; REQ-017 prevents it in legal streams.
REQ-028 exc_flush does not abort an in-flight MDU op; it blocks only a same-cycle mdu_start.
REQ-029 stall_count increments by 1 on each cycle where stall=1 and saturates at 32'hFFFF_FFFF.
REQ-030 Counter width is ceil(log2(max(MULT_CYCLES,DIV_CYCLES))) bits; MULT_CYCLES and DIV_CYCLES are each at least 1.

Reset
REQ-031 While reset=1 at a clock edge: FSM goes to IDLE, counter=0, stall_count=0.
REQ-032 The registered outputs mdu_busy and mdu_done are 0 in the cycle after reset.
REQ-033 A reset asserted mid-BUSY abandons the op; no mdu_done pulse is produced.
REQ-034 The combinational outputs follow REQ-016..021 during reset; the pipeline controller gates stage activity during reset.

Structure
REQ-035 Shared package: MDU FSM state enum, default MULT_CYCLES/DIV_CYCLES constants, register-number width (5).
REQ-036 One sub-module, mdu_busy_timer, holds the FSM, counter, mdu_busy and mdu_done.
REQ-037 Hazard/flush logic and stall_count are in the top-level module.

Verification
REQ-038 Load-use: ex_is_load=1, ex_rd=8, id_uses_rs=1, id_rs=8 for 1 cycle -> pc_ena=0, if_id_ena=0, id_exe_flush=1 that cycle; stall_count 0->1.
REQ-039 $zero: ex_is_load=1, ex_rd=0, id_rs=0, id_uses_rs=1 -> no stall, pc_ena=1.
REQ-040 Divide: mdu_start=1, mdu_is_div=1 at cycle 0 -> mdu_busy=1 for cycles 1..33, mdu_done=1 at cycle 34; with id_mdu_use=1 throughout -> stall for those 33 cycles.
REQ-041 Flush priority: load-use hazard + branch_taken + exc_flush together -> all three flushes=1, pc_ena=1, stall_count unchanged.
REQ-042 Branch during stall: branch_taken=1 with load-use hazard -> if_id_flush=0; next cycle with no hazard and branch_taken=1 -> if_id_flush=1.
REQ-043 Reset mid-multiply: reset at cycle 2 of a MULT -> mdu_busy=0 the next cycle, mdu_done never pulses, stall_count=0.
